// File: rtl/song_recorder_if.sv
// song_recorder_if
// Write port of the song memory: a one-cycle write strobe, the 5-bit entry address and the
// (note, duration) pair stored there.
//   master : driven by the recorder (song_recorder)
//   slave  : seen by the song memory
//   wr_en        1   write strobe, high for one cycle per entry
//   wr_addr      5   entry address
//   wr_note      4   note value
//   wr_duration  26  duration in clock cycles
interface song_recorder_if;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [3:0]  wr_note;
  logic [25:0] wr_duration;

  modport master (output wr_en, output wr_addr, output wr_note, output wr_duration);
  modport slave  (input  wr_en, input  wr_addr, input  wr_note, input  wr_duration);
endinterface

// File: rtl/song_recorder.sv
// song_recorder
// Record-mode writer for the song memory. It times each key hold and writes one
// (note, duration) entry per accepted note at sequential addresses. The song is closed with
// an end marker, which is note 0 with duration 0.
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   record_en      level; high = record mode, low = abort / idle
//   user_input     4-bit note value
//   isvalid        high while a key is held
//   comfirm_button level; finishes the song
//   wr_bus         song memory write port (song_recorder_if.master)
//   note_count     entries written so far, excluding the end marker
//   recording      high in WAIT_KEY / HOLD / WRITE
//   done           high after the end marker, until record_en falls
// Optional feature: define REST_CAPTURE_EN to also record silent gaps between notes as
// rest entries (note 0, duration = gap length).
module song_recorder #(
  parameter int MIN_DUR   = 1_000_000,
  parameter int MAX_NOTES = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  record_en,
  input  logic [3:0]            user_input,
  input  logic                  isvalid,
  input  logic                  comfirm_button,
  song_recorder_if.master       wr_bus,
  output logic [4:0]            note_count,
  output logic                  recording,
  output logic                  done
);

  typedef enum logic [2:0] {IDLE, WAIT_KEY, HOLD, WRITE, FINISH, DONE} state_t;

  localparam logic [25:0] MIN_V = 26'(MIN_DUR);
  localparam logic [4:0]  MAX_V = 5'(MAX_NOTES);

  state_t      state_q, state_d;
  logic [4:0]  ptr_q, ptr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  note_q, note_d;
  logic [25:0] dur_q, dur_d;
  logic        pend_q, pend_d;
  logic        live_q, live_d;
  logic        wr_en_q, wr_en_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [3:0]  wr_note_q, wr_note_d;
  logic [25:0] wr_dur_q, wr_dur_d;
  logic        recording_q, recording_d;
  logic        done_q, done_d;
`ifdef REST_CAPTURE_EN
  localparam logic [4:0]  REST_LIMIT = 5'(MAX_NOTES - 2);
  logic [25:0] gap_q, gap_d;
`endif

  function automatic logic [25:0] sat_inc(input logic [25:0] v);
    return (v == '1) ? v : v + 26'd1;
  endfunction

  // pend_q remembers a confirm that ended a hold, so WRITE finishes the song afterwards.
  // live_q marks that the hold ended on a note change: note_q/dur_q then already track the
  // new key, so its timing keeps running through the WRITE cycle.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    note_d    = note_q;
    dur_d     = dur_q;
    pend_d    = pend_q;
    live_d    = live_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_note_d = wr_note_q;
    wr_dur_d  = wr_dur_q;
`ifdef REST_CAPTURE_EN
    gap_d     = gap_q;
`endif

    if (state_q == IDLE) begin
      ptr_d  = '0;
      cnt_d  = '0;
      dur_d  = '0;
      pend_d = 1'b0;
      live_d = 1'b0;
`ifdef REST_CAPTURE_EN
      gap_d  = '0;
`endif
    end

    if (!record_en) begin
      state_d = IDLE;
      pend_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_d = WAIT_KEY;

        WAIT_KEY: begin
          if (comfirm_button) begin
            state_d = FINISH;
          end else if (isvalid) begin
            note_d  = user_input;
            dur_d   = 26'd1;
            state_d = HOLD;
`ifdef REST_CAPTURE_EN
            // Gap counting only matters once a note exists; the rest is written alongside the
            // new press without disturbing its hold timing.
            if (cnt_q != 5'd0 && cnt_q <= REST_LIMIT && gap_q >= MIN_V) begin
              wr_en_d   = 1'b1;
              wr_addr_d = ptr_q;
              wr_note_d = 4'd0;
              wr_dur_d  = gap_q;
              ptr_d     = ptr_q + 5'd1;
              cnt_d     = cnt_q + 5'd1;
            end
            gap_d = '0;
          end else begin
            gap_d = sat_inc(gap_q);
`endif
          end
        end

        HOLD: begin
          if (isvalid && user_input == note_q && !comfirm_button) begin
            dur_d = sat_inc(dur_q);
          end else begin
            pend_d = comfirm_button;
`ifdef REST_CAPTURE_EN
            gap_d  = 26'd1;
`endif
            if (dur_q >= MIN_V) begin
              wr_en_d   = 1'b1;
              wr_addr_d = ptr_q;
              wr_note_d = note_q;
              wr_dur_d  = dur_q;
              ptr_d     = ptr_q + 5'd1;
              cnt_d     = cnt_q + 5'd1;
              live_d    = isvalid;
              note_d    = user_input;
              dur_d     = 26'd1;
              state_d   = WRITE;
            end else begin
              state_d = comfirm_button ? FINISH : WAIT_KEY;
            end
          end
        end

        WRITE: begin
          if (pend_q || comfirm_button || cnt_q == MAX_V) begin
            state_d = FINISH;
          end else if (isvalid && live_q) begin
            if (user_input == note_q) begin
              dur_d = sat_inc(dur_q);
            end else begin
              note_d = user_input;
              dur_d  = 26'd1;
            end
            state_d = HOLD;
          end else begin
`ifdef REST_CAPTURE_EN
            gap_d = live_q ? 26'd1 : sat_inc(gap_q);
`endif
            state_d = WAIT_KEY;
          end
          live_d = 1'b0;
        end

        FINISH: begin
          wr_en_d   = 1'b1;
          wr_addr_d = ptr_q;
          wr_note_d = 4'd0;
          wr_dur_d  = '0;
          state_d   = DONE;
        end

        DONE: state_d = DONE;

        default: state_d = IDLE;
      endcase
    end

    recording_d = (state_d == WAIT_KEY) || (state_d == HOLD) || (state_d == WRITE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      note_q      <= '0;
      dur_q       <= '0;
      pend_q      <= 1'b0;
      live_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_note_q   <= '0;
      wr_dur_q    <= '0;
      recording_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef REST_CAPTURE_EN
      gap_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      note_q      <= note_d;
      dur_q       <= dur_d;
      pend_q      <= pend_d;
      live_q      <= live_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_note_q   <= wr_note_d;
      wr_dur_q    <= wr_dur_d;
      recording_q <= recording_d;
      done_q      <= done_d;
`ifdef REST_CAPTURE_EN
      gap_q       <= gap_d;
`endif
    end
  end

  assign wr_bus.wr_en       = wr_en_q;
  assign wr_bus.wr_addr     = wr_addr_q;
  assign wr_bus.wr_note     = wr_note_q;
  assign wr_bus.wr_duration = wr_dur_q;
  assign note_count         = cnt_q;
  assign recording          = recording_q;
  assign done               = done_q;

endmodule

// File: tb/tb_song_recorder.sv
// tb_song_recorder
// Plays songs (lists of key presses with hold length and following gap) into song_recorder
// and compares every memory write, note_count, recording and done against a song-level model.
// Optional feature under test when REST_CAPTURE_EN is defined.
module tb_song_recorder;
  localparam int MIN_DUR   = 4;
  localparam int MAX_NOTES = 31;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       record_en = 1'b0;
  logic [3:0] user_input = 4'd0;
  logic       isvalid = 1'b0;
  logic       comfirm_button = 1'b0;
  logic [4:0] note_count;
  logic       recording;
  logic       done;

  song_recorder_if bus ();

  song_recorder #(.MIN_DUR(MIN_DUR), .MAX_NOTES(MAX_NOTES)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .record_en(record_en),
    .user_input(user_input),
    .isvalid(isvalid),
    .comfirm_button(comfirm_button),
    .wr_bus(bus),
    .note_count(note_count),
    .recording(recording),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  addr;
    logic [3:0]  note;
    logic [25:0] dur;
  } entry_t;

  typedef struct {
    int note;
    int len;
    int gap;
  } press_t;

  entry_t got_q[$];
  entry_t exp_q[$];
  press_t song[$];
  int     checks = 0;
  int     failures = 0;
  int     exp_cnt;
  bit     exp_done;

  // Every write strobe seen by the memory side is logged away from the active edge.
  always @(negedge clk) begin
    if (rst_n && bus.wr_en) got_q.push_back({bus.wr_addr, bus.wr_note, bus.wr_duration});
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Song-level model: each press held at least MIN_DUR cycles becomes an entry of its length;
  // with rest capture, a gap of at least MIN_DUR before a press becomes a rest entry once a
  // note exists and two slots remain. A full table or a confirm closes the song.
  task automatic buildExpected(input bit confirm);
    int cnt = 0;
    bit fin = 0;
    exp_q.delete();
    for (int i = 0; i < song.size(); i++) begin
      if (fin) break;
`ifdef REST_CAPTURE_EN
      if (i > 0 && song[i-1].gap >= MIN_DUR && cnt >= 1 && cnt <= MAX_NOTES - 2) begin
        exp_q.push_back({5'(cnt), 4'd0, 26'(song[i-1].gap)});
        cnt++;
      end
`endif
      if (song[i].len >= MIN_DUR) begin
        exp_q.push_back({5'(cnt), 4'(song[i].note), 26'(song[i].len)});
        cnt++;
        if (cnt == MAX_NOTES) begin
          exp_q.push_back({5'(cnt), 4'd0, 26'd0});
          fin = 1;
        end
      end
    end
    if (!fin && confirm) begin
      exp_q.push_back({5'(cnt), 4'd0, 26'd0});
      fin = 1;
    end
    exp_cnt  = cnt;
    exp_done = fin;
  endtask

  // Inputs change on the falling edge, so each press is sampled for exactly len rising edges.
  task automatic applyStimulus(input bit confirm);
    for (int i = 0; i < song.size(); i++) begin
      user_input = 4'(song[i].note);
      isvalid    = 1'b1;
      repeat (song[i].len) @(negedge clk);
      if (song[i].gap > 0) begin
        isvalid    = 1'b0;
        user_input = 4'($urandom_range(0, 15));
        repeat (song[i].gap) @(negedge clk);
      end
    end
    if (confirm) begin
      comfirm_button = 1'b1;
      @(negedge clk);
      comfirm_button = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic runSong(input string tag, input bit confirm);
    buildExpected(confirm);
    got_q.delete();
    record_en = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(confirm);
    checkOutput({tag, " writes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checkOutput($sformatf("%s e%0d addr", tag, i), got_q[i].addr, exp_q[i].addr);
      checkOutput($sformatf("%s e%0d note", tag, i), got_q[i].note, exp_q[i].note);
      checkOutput($sformatf("%s e%0d dur", tag, i), got_q[i].dur, exp_q[i].dur);
    end
    checkOutput({tag, " note_count"}, note_count, exp_cnt);
    checkOutput({tag, " done"}, done, exp_done);
    checkOutput({tag, " recording"}, recording, !exp_done);
    record_en = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput({tag, " idle done"}, done, 0);
    checkOutput({tag, " idle recording"}, recording, 0);
    checkOutput({tag, " idle count"}, note_count, 0);
  endtask

  task automatic addPress(input int note, input int len, input int gap);
    press_t p;
    p.note = note;
    p.len  = len;
    p.gap  = gap;
    song.push_back(p);
  endtask

  task automatic makeRandomSong();
    int n;
    int prev_note = -1;
    int prev_gap = 1;
    press_t p;
    song.delete();
    n = $urandom_range(3, 40);
    for (int i = 0; i < n; i++) begin
      p.note = $urandom_range(0, 15);
      while (prev_gap == 0 && p.note == prev_note) p.note = $urandom_range(0, 15);
      p.len = $urandom_range(0, 1) ? $urandom_range(1, MIN_DUR - 1) : $urandom_range(MIN_DUR, MIN_DUR + 12);
      p.gap = (p.len >= MIN_DUR && i != n - 1 && $urandom_range(0, 2) == 0) ? 0 : $urandom_range(2, 10);
      song.push_back(p);
      prev_note = p.note;
      prev_gap  = p.gap;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset wr_en", bus.wr_en, 0);
    checkOutput("reset wr_addr", bus.wr_addr, 0);
    checkOutput("reset wr_note", bus.wr_note, 0);
    checkOutput("reset wr_duration", bus.wr_duration, 0);
    checkOutput("reset note_count", note_count, 0);
    checkOutput("reset recording", recording, 0);
    checkOutput("reset done", done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    song.delete(); addPress(5, 10, 3);
    runSong("single", 0);

    song.delete(); addPress(3, 2, 3); addPress(9, 5, 3);
    runSong("glitch", 1);

    song.delete(); addPress(1, 6, 0); addPress(2, 8, 3);
    runSong("legato", 1);

    song.delete();
    for (int i = 0; i < 33; i++) addPress((i % 15) + 1, 5, 3);
    runSong("full", 0);

    // Abort while a key is held: nothing may be written and the next song restarts at 0.
    got_q.delete();
    record_en = 1'b1;
    repeat (2) @(negedge clk);
    user_input = 4'd7;
    isvalid    = 1'b1;
    repeat (5) @(negedge clk);
    record_en = 1'b0;
    repeat (3) @(negedge clk);
    isvalid = 1'b0;
    checkOutput("abort writes", got_q.size(), 0);
    checkOutput("abort recording", recording, 0);
    checkOutput("abort done", done, 0);
    song.delete(); addPress(8, 6, 3);
    runSong("restart", 1);

    song.delete(); addPress(4, 5, 7); addPress(6, 5, 3);
    runSong("rest", 1);

    for (int s = 0; s < 20; s++) begin
      makeRandomSong();
      runSong($sformatf("rand%0d", s), $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
